// File: rtl/pipeline_pkg.sv
// Shared types and widths for the RV32I pipeline sequencer.
// Holds the FSM state encoding, forwarding selects and bus widths.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HALT  = 3'd4
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detector and EX operand forwarding selects.
// Ports: ID/EX/MEM/WB register ids and write flags in; o_load_use, o_fwd_a/b out.
module hazard_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic            i_id_use_rs1,
    input  logic            i_id_use_rs2,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_ex_mem_read,
    input  logic [RA_W-1:0] i_ex_rs1,
    input  logic [RA_W-1:0] i_ex_rs2,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic            i_mem_reg_write,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_wb_reg_write,
    output logic            o_load_use,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b
);

    logic w_mem_ok;
    logic w_wb_ok;

    // x0 is hardwired zero, so a write to it is never a forwarding source.
    assign w_mem_ok = i_mem_reg_write && (i_mem_rd != '0);
    assign w_wb_ok  = i_wb_reg_write && (i_wb_rd != '0);

    assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
        ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
         (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        o_fwd_a = FWD_RF;
        if (w_mem_ok && (i_mem_rd == i_ex_rs1)) begin
            o_fwd_a = FWD_MEM;
        end else if (w_wb_ok && (i_wb_rd == i_ex_rs1)) begin
            o_fwd_a = FWD_WB;
        end
    end

    always_comb begin
        o_fwd_b = FWD_RF;
        if (w_mem_ok && (i_mem_rd == i_ex_rs2)) begin
            o_fwd_b = FWD_MEM;
        end else if (w_wb_ok && (i_wb_rd == i_ex_rs2)) begin
            o_fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: boot, run/pause/halt FSM,
// stalls, flushes, forwarding selects and a saturating stall counter.
// Ports: clk/reset(active-low async), run_en, hazard inputs; stage enables,
// flushes, PC load controls, fwd_a/b, state, halted, stall_count out.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    initial_address,
    input  logic               run_en,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RA_W-1:0]    ex_rd,
    input  logic               ex_mem_read,
    input  logic [RA_W-1:0]    mem_rd,
    input  logic [RA_W-1:0]    wb_rd,
    input  logic               mem_reg_write,
    input  logic               wb_reg_write,
    input  logic               ex_br_taken,
    input  logic [XLEN-1:0]    ex_br_target,
    input  logic               dmem_busy,
    input  logic               wb_halt,
    output logic               pc_en,
    output logic               pc_load,
    output logic [XLEN-1:0]    pc_load_value,
    output logic               if_id_en,
    output logic               id_ex_en,
    output logic               ex_mem_en,
    output logic               mem_wb_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [2:0]         state,
    output logic               halted,
    output logic [STALL_W-1:0] stall_count
);

    ctrl_state_e        r_state;
    logic [RA_W-1:0]    r_ex_rs1;
    logic [RA_W-1:0]    r_ex_rs2;
    logic [STALL_W-1:0] r_stall_count;
    logic               w_load_use;
    logic               w_stall_inc;

    hazard_fwd_unit u_hfu (
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_use_rs1    (id_use_rs1),
        .i_id_use_rs2    (id_use_rs2),
        .i_ex_rd         (ex_rd),
        .i_ex_mem_read   (ex_mem_read),
        .i_ex_rs1        (r_ex_rs1),
        .i_ex_rs2        (r_ex_rs2),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_load_use      (w_load_use),
        .o_fwd_a         (fwd_a),
        .o_fwd_b         (fwd_b)
    );

    // Pipeline control is a pure function of the current state and inputs.
    always_comb begin
        pc_en         = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        if (r_state == ST_BOOT) begin
            pc_en         = 1'b1;
            pc_load       = 1'b1;
            pc_load_value = initial_address;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (wb_halt) begin
                // Only the halting instruction retires.
                mem_wb_en = 1'b1;
            end else if (dmem_busy) begin
                // Whole pipe frozen; a held branch is seen again afterwards.
            end else if (ex_br_taken) begin
                pc_en         = 1'b1;
                pc_load       = 1'b1;
                pc_load_value = ex_br_target;
                if_id_en      = 1'b1;
                id_ex_en      = 1'b1;
                ex_mem_en     = 1'b1;
                mem_wb_en     = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
            end else if (w_load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    // Count only cycles actually lost; a branch squashes a load-use bubble.
    assign w_stall_inc = (r_state == ST_RUN) && !wb_halt &&
        (dmem_busy || (w_load_use && !ex_br_taken));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (run_en) r_state <= ST_BOOT;
                ST_BOOT:  r_state <= ST_RUN;
                ST_RUN: begin
                    if (wb_halt)      r_state <= ST_HALT;
                    else if (!run_en) r_state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (wb_halt)     r_state <= ST_HALT;
                    else if (run_en) r_state <= ST_RUN;
                end
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else if (id_ex_flush) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else if (id_ex_en) begin
            r_ex_rs1 <= id_rs1;
            r_ex_rs2 <= id_rs2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (w_stall_inc && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign state       = r_state;
    assign halted      = (r_state == ST_HALT);
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: boot, stalls, branches,
// forwarding, memory freeze, pause, reset and halt.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] initial_address;
    logic        run_en;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        mem_reg_write;
    logic        wb_reg_write;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        dmem_busy;
    logic        wb_halt;
    logic        pc_en;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    logic [4:0] en;
    logic [1:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_ex_flush};

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .initial_address (initial_address),
        .run_en          (run_en),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_reg_write   (mem_reg_write),
        .wb_reg_write    (wb_reg_write),
        .ex_br_taken     (ex_br_taken),
        .ex_br_target    (ex_br_target),
        .dmem_busy       (dmem_busy),
        .wb_halt         (wb_halt),
        .pc_en           (pc_en),
        .pc_load         (pc_load),
        .pc_load_value   (pc_load_value),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .state           (state),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs checked 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        initial_address = 32'h100;
        run_en = 1'b0;
        id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0;
        mem_rd = '0; wb_rd = '0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        ex_br_taken = 1'b0; ex_br_target = '0;
        dmem_busy = 1'b0; wb_halt = 1'b0;

        nxt(); nxt(); #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt", 32'(stall_count), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_misc", {pc_load, fl, fwd_a, fwd_b, halted}, 32'd0);

        // Boot
        nxt(); reset = 1'b1; run_en = 1'b1;
        #1 check("idle_en", 32'(en), 32'd0);
        nxt(); #1;
        check("boot_state", 32'(state), 32'd1);
        check("boot_load", 32'(pc_load), 32'd1);
        check("boot_val", pc_load_value, 32'h100);
        check("boot_flush", 32'(fl), 32'b11);
        check("boot_pcen", 32'(pc_en), 32'd1);
        nxt(); #1;
        check("run_state", 32'(state), 32'd2);
        check("run_en", 32'(en), 32'b11111);
        check("run_fl", {pc_load, fl}, 32'd0);

        // Load-use on rs1
        nxt();
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        check("lu_en", 32'(en), 32'b00111);
        check("lu_fl", 32'(fl), 32'b01);
        check("lu_cnt0", 32'(stall_count), 32'd0);
        nxt(); ex_mem_read = 1'b0;
        #1;
        check("lu_cnt1", 32'(stall_count), 32'd1);
        check("lu_after", 32'(en), 32'b11111);

        // Load-use on rs2, rd=x0 must not stall
        nxt();
        ex_mem_read = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1 check("lu_x0", 32'(en), 32'b11111);
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1 check("lu_rs2", 32'(en), 32'b00111);

        // Branch in the same cycle as load-use
        ex_br_taken = 1'b1; ex_br_target = 32'h40;
        #1;
        check("br_load", 32'(pc_load), 32'd1);
        check("br_val", pc_load_value, 32'h40);
        check("br_fl", 32'(fl), 32'b11);
        check("br_en", 32'(en), 32'b11111);
        nxt();
        ex_br_taken = 1'b0; ex_mem_read = 1'b0;
        id_use_rs2 = 1'b0; id_rs2 = 5'd0;
        #1 check("br_cnt", 32'(stall_count), 32'd1);

        // Forwarding
        nxt(); id_rs1 = 5'd3;
        nxt();
        mem_rd = 5'd3; wb_rd = 5'd3;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        #1 check("fwd_mem", 32'(fwd_a), 32'b01);
        check("fwd_b_rf", 32'(fwd_b), 32'b00);
        mem_reg_write = 1'b0;
        #1 check("fwd_wb", 32'(fwd_a), 32'b10);
        nxt(); id_rs1 = 5'd0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        nxt();
        mem_rd = 5'd0; wb_rd = 5'd0;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        #1 check("fwd_x0", 32'(fwd_a), 32'b00);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // dmem_busy holds a taken branch for 4 cycles
        nxt();
        ex_br_taken = 1'b1; ex_br_target = 32'h80; dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("busy_en", 32'(en), 32'd0);
            check("busy_ld", {pc_load, fl}, 32'd0);
            nxt();
        end
        dmem_busy = 1'b0;
        #1;
        check("rel_load", 32'(pc_load), 32'd1);
        check("rel_val", pc_load_value, 32'h80);
        check("busy_cnt", 32'(stall_count), 32'd5);
        nxt(); ex_br_taken = 1'b0;

        // Pause and resume
        run_en = 1'b0;
        nxt(); #1;
        check("pause_st", 32'(state), 32'd3);
        check("pause_en", 32'(en), 32'd0);
        run_en = 1'b1;
        nxt(); #1;
        check("resume_st", 32'(state), 32'd2);
        check("resume_ld", 32'(pc_load), 32'd0);

        // Asynchronous reset mid-RUN
        #1 reset = 1'b0;
        #1;
        check("arst_st", 32'(state), 32'd0);
        check("arst_cnt", 32'(stall_count), 32'd0);
        check("arst_en", 32'(en), 32'd0);
        nxt(); reset = 1'b1;
        nxt(); nxt(); #1;
        check("reboot", 32'(state), 32'd2);

        // Halt
        wb_halt = 1'b1;
        #1 check("halt_en", 32'(en), 32'b00001);
        nxt(); wb_halt = 1'b0;
        #1;
        check("halt_st", 32'(state), 32'd4);
        check("halted", 32'(halted), 32'd1);
        check("halt_en0", 32'(en), 32'd0);
        run_en = 1'b0;
        nxt(); run_en = 1'b1;
        nxt(); #1;
        check("halt_hold", {29'd0, state}, 32'd4);
        check("halted2", 32'(halted), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
